sram_port_ctrl: RTL and testbench

- Responder end of the on-board SRAM request interface. The memory arbiter issues one single-word request at a time (BaseRAM or ExtRAM channel); one instance sits behind each channel.
- Converts each request into a timed, active-low asynchronous-SRAM pin sequence (ce_n/oe_n/we_n/be_n, split data bus tristated at top level).
- Returns read data with a valid pulse, or a write-done pulse.

---
 rtl/sram_port_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Responder for one asynchronous-SRAM channel: turns single-word arbiter requests into
// registered active-low ce_n/oe_n/we_n/be_n pin sequences and reports completion.
module sram_port_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_PULSE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_en_n,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              wr_done,
  output logic              req_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_o,
  output logic              ram_data_oe,
  input  logic [31:0]       ram_data_i,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  localparam logic [3:0] RdLoad = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WpLoad = 4'(WR_PULSE - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_data_o_q, ram_data_o_d;
  logic              ram_data_oe_q, ram_data_oe_d;
  logic [3:0]        ram_be_n_q, ram_be_n_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              req_err_q, req_err_d;

  logic [31:0] offset;
  logic        in_range;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (offset >> (ADDR_W + 2)) == 32'd0;

  assign req_ready = (state_q == StIdle);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ram_addr_d    = ram_addr_q;
    ram_data_o_d  = ram_data_o_q;
    ram_data_oe_d = ram_data_oe_q;
    ram_be_n_d    = ram_be_n_q;
    ram_ce_n_d    = ram_ce_n_q;
    ram_oe_n_d    = ram_oe_n_q;
    ram_we_n_d    = ram_we_n_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wr_done_d     = 1'b0;
    req_err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!req_en_n) begin
          if (!in_range) begin
            req_err_d = 1'b1;
          end else begin
            ram_addr_d = offset[ADDR_W+1:2];
            if (!req_we) begin
              state_d       = StRd;
              cnt_d         = RdLoad;
              ram_ce_n_d    = 1'b0;
              ram_oe_n_d    = 1'b0;
              ram_be_n_d    = 4'h0;
              ram_data_oe_d = 1'b0;
            end else if (req_be == 4'h0) begin
              // Nothing to store: complete immediately without touching the pins.
              wr_done_d = 1'b1;
            end else begin
              state_d       = StWrSetup;
              ram_ce_n_d    = 1'b0;
              ram_oe_n_d    = 1'b1;
              ram_we_n_d    = 1'b1;
              ram_data_oe_d = 1'b1;
              ram_be_n_d    = ~req_be;
              ram_data_o_d  = req_wdata;
            end
          end
        end
      end

      StRd: begin
        if (cnt_q == 4'd0) begin
          state_d       = StIdle;
          rdata_d       = ram_data_i;
          rdata_valid_d = 1'b1;
          ram_ce_n_d    = 1'b1;
          ram_oe_n_d    = 1'b1;
          ram_be_n_d    = 4'hF;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StWrSetup: begin
        state_d    = StWrPulse;
        cnt_d      = WpLoad;
        ram_we_n_d = 1'b0;
      end

      StWrPulse: begin
        if (cnt_q == 4'd0) begin
          state_d    = StWrHold;
          ram_we_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StWrHold: begin
        state_d       = StIdle;
        ram_ce_n_d    = 1'b1;
        ram_be_n_d    = 4'hF;
        ram_data_oe_d = 1'b0;
        wr_done_d     = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      ram_addr_q    <= '0;
      ram_data_o_q  <= 32'd0;
      ram_data_oe_q <= 1'b0;
      ram_be_n_q    <= 4'hF;
      ram_ce_n_q    <= 1'b1;
      ram_oe_n_q    <= 1'b1;
      ram_we_n_q    <= 1'b1;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_o_q  <= ram_data_o_d;
      ram_data_oe_q <= ram_data_oe_d;
      ram_be_n_q    <= ram_be_n_d;
      ram_ce_n_q    <= ram_ce_n_d;
      ram_oe_n_q    <= ram_oe_n_d;
      ram_we_n_q    <= ram_we_n_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wr_done_q     <= wr_done_d;
      req_err_q     <= req_err_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_data_o  = ram_data_o_q;
  assign ram_data_oe = ram_data_oe_q;
  assign ram_be_n    = ram_be_n_q;
  assign ram_ce_n    = ram_ce_n_q;
  assign ram_oe_n    = ram_oe_n_q;
  assign ram_we_n    = ram_we_n_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_done     = wr_done_q;
  assign req_err     = req_err_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl: a behavioural SRAM on the pins, a word-level memory
// model predicting responses, and a monitor checking pulses, timing and pin protocol.
module tb_sram_port_ctrl;

  localparam logic [31:0] Base = 32'h8000_0000;
  localparam int unsigned Aw   = 20;
  localparam int unsigned Rdc  = 2;
  localparam int unsigned Wrp  = 1;

  logic          clk;
  logic          reset;
  logic          req_en_n;
  logic          req_we;
  logic [3:0]    req_be;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          wr_done;
  logic          req_err;
  logic [Aw-1:0] ram_addr;
  logic [31:0]   ram_data_o;
  logic          ram_data_oe;
  logic [31:0]   ram_data_i;
  logic [3:0]    ram_be_n;
  logic          ram_ce_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  sram_port_ctrl #(
    .BASE_ADDR(Base),
    .ADDR_W   (Aw),
    .RD_CYCLES(Rdc),
    .WR_PULSE (Wrp)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_en_n   (req_en_n),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .wr_done    (wr_done),
    .req_err    (req_err),
    .ram_addr   (ram_addr),
    .ram_data_o (ram_data_o),
    .ram_data_oe(ram_data_oe),
    .ram_data_i (ram_data_i),
    .ram_be_n   (ram_be_n),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 read data, 1 write done, 2 address error
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   exp_next = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_edge = reset;
  end

  // Power-up contents of the chip; word 4 holds a recognisable pattern.
  function automatic logic [31:0] init_val(input int w);
    logic [31:0] wl;
    wl = w;
    if (w == 4) return 32'hDEAD_BEEF;
    return (wl * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Behavioural asynchronous SRAM driven purely by the pins.
  logic [31:0] sram[int];
  always @(negedge clk) begin
    logic [31:0] v;
    int a;
    a = int'(ram_addr);
    if (!ram_ce_n && !ram_we_n) begin
      v = sram.exists(a) ? sram[a] : init_val(a);
      for (int b = 0; b < 4; b++) if (!ram_be_n[b]) v[8*b +: 8] = ram_data_o[8*b +: 8];
      sram[a] = v;
    end
    if (!ram_ce_n && !ram_oe_n) ram_data_i = sram.exists(a) ? sram[a] : init_val(a);
    else ram_data_i = 32'h0BAD_F00D;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expected responses when the DUT pulses, and checks pin protocol.
  int   oe_run = 0;
  int   we_run = 0;
  int   ce_run = 0;
  logic saw_rd = 1'b0;
  logic prev_data_oe = 1'b0;
  logic prev_oe_n = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] got;
    got = {req_err, wr_done, rdata_valid};
    if (rst_edge) begin
      sb.delete();
      oe_run = 0;
      we_run = 0;
      ce_run = 0;
      saw_rd = 1'b0;
      chk("reset_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_data_oe, got, req_ready},
          {1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'b000, 1'b1});
      chk("reset_rdata", {ram_addr, rdata}, '0);
    end else begin
      chk("req_ready", req_ready, (cyc + 1 >= exp_next));
      if (got != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", got, 3'b000);
        end else begin
          e = sb.pop_front();
          chk("resp_kind", got, 3'b001 << e.kind);
          chk("resp_cycle", cyc, e.due);
          if (e.kind == 0) chk("rdata", rdata, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("resp_missing", got, 3'b001 << sb[0].kind);
        void'(sb.pop_front());
      end

      if (!ram_oe_n)
        chk("rd_pins", {ram_ce_n, ram_data_oe, prev_data_oe, ram_we_n, ram_be_n},
            {1'b0, 1'b0, 1'b0, 1'b1, 4'h0});
      if (ram_data_oe) chk("wr_window", {ram_ce_n, ram_oe_n, prev_oe_n}, 3'b011);
      if (!ram_we_n) chk("we_window", {ram_ce_n, ram_data_oe, prev_data_oe}, 3'b011);
      if (ram_ce_n)
        chk("idle_pins", {ram_oe_n, ram_we_n, ram_be_n, ram_data_oe}, {1'b1, 1'b1, 4'hF, 1'b0});

      if (!ram_oe_n) begin
        oe_run++;
        saw_rd = 1'b1;
      end else if (oe_run != 0) begin
        chk("oe_width", oe_run, Rdc);
        oe_run = 0;
      end
      if (!ram_we_n) we_run++;
      else if (we_run != 0) begin
        chk("we_width", we_run, Wrp);
        we_run = 0;
      end
      if (!ram_ce_n) ce_run++;
      else if (ce_run != 0) begin
        chk("ce_width", ce_run, saw_rd ? Rdc : Wrp + 2);
        ce_run = 0;
        saw_rd = 1'b0;
      end
    end
    prev_data_oe = ram_data_oe;
    prev_oe_n    = ram_oe_n;
  end

  // Driver plus word-level reference model.
  logic [31:0] mdl[int];

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic [31:0] off;
    logic [31:0] v;
    int w, t0, wait_n;
    exp_t e;
    req_en_n  = 1'b0;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    wait_n    = 0;
    while (!req_ready && wait_n < 64) begin
      @(negedge clk);
      wait_n++;
    end
    if (!req_ready) begin
      req_en_n = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    t0  = cyc;
    off = addr - Base;
    w   = int'(off >> 2);
    e.data = 32'd0;
    if (off >= (32'd1 << (Aw + 2))) begin
      e.kind   = 2;
      e.due    = t0;
      exp_next = t0 + 1;
    end else if (!we) begin
      e.kind   = 0;
      e.data   = mdl.exists(w) ? mdl[w] : init_val(w);
      e.due    = t0 + Rdc;
      exp_next = t0 + Rdc + 1;
    end else if (be == 4'h0) begin
      e.kind   = 1;
      e.due    = t0;
      exp_next = t0 + 1;
    end else begin
      v = mdl.exists(w) ? mdl[w] : init_val(w);
      for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
      mdl[w]   = v;
      e.kind   = 1;
      e.due    = t0 + Wrp + 2;
      exp_next = t0 + Wrp + 3;
    end
    sb.push_back(e);
    req_en_n  = 1'b1;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  initial begin
    logic [31:0] a;
    int k;
    reset     = 1'b1;
    req_en_n  = 1'b0;
    req_we    = 1'b0;
    req_be    = 4'h0;
    req_addr  = Base + 32'h10;
    req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    issue(1'b0, 4'h0, Base + 32'h10, 32'd0);
    issue(1'b1, 4'b0101, Base + 32'h0C, 32'h1234_5678);
    issue(1'b0, 4'h0, Base + 32'h0C, 32'd0);
    repeat (2) @(negedge clk);
    issue(1'b0, 4'h0, Base + 32'h400000, 32'd0);
    issue(1'b1, 4'hF, Base - 32'd4, 32'hFFFF_FFFF);
    issue(1'b1, 4'h0, Base + 32'h20, 32'hCAFE_F00D);
    issue(1'b0, 4'h0, Base + 32'h20, 32'd0);
    issue(1'b1, 4'hF, Base + 32'h20, 32'hA5A5_0001);
    issue(1'b1, 4'b1000, Base + 32'h0C, 32'h9900_0000);
    issue(1'b0, 4'h0, Base + 32'h0C, 32'd0);

    // Reset landing in the write-pulse cycle must abort the write cleanly.
    repeat (2) @(negedge clk);
    issue(1'b1, 4'hF, Base + 32'd4000, 32'h7777_7777);
    k = 0;
    @(negedge clk);
    while (ram_we_n && k < 10) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 exp_next = 0;
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 4'h0, Base + 32'h10, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = Base - 32'd4 - ($urandom_range(0, 255) << 2);
          1:       a = Base + 32'h40_0000 + $urandom_range(0, 1023);
          default: a = $urandom;
        endcase
      end else begin
        a = Base + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      end
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
